uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tx_baud_gen.sv | 23 ++
 rtl/uart_tx.sv | 98 +++++++++
 tb/tb_uart_tx.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, frame geometry and the baud divisor
// calculation, common to the transmitter and receiver.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned TICK_W     = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W      = $clog2(DATA_BITS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  // Clocks per oversample tick, truncated; never below 1.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    int unsigned d;
    d = clk_freq / (baud * OVERSAMPLE);
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Oversample tick generator: one-cycle pulse every DIV clocks, with a
// synchronous clear that restarts the count for frame alignment.
module baud_gen #(
  parameter int unsigned DIV = 651
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1)) && !clr;

  always_ff @(posedge clk) begin
    if (rst || clr || tick) cnt <= '0;
    else                    cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: 16x oversampled bit timing, LSB first, registered
// line output, STATUS high while idle and ready to accept a byte.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] DATA,
  input  logic       TX_EN,
  output logic       TX,
  output logic       STATUS
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD);

  uart_state_t          state, state_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [TICK_W-1:0]    tick_cnt, tick_cnt_nxt;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic                 tick, accept, tick_last, last_bit;
  logic                 tx_d, tx_q;

  assign accept    = (state == ST_IDLE) && TX_EN;
  assign tick_last = tick && (tick_cnt == TICK_W'(OVERSAMPLE - 1));
  assign last_bit  = (bit_cnt == BIT_W'(DATA_BITS - 1));

  baud_gen #(.DIV(DIV)) u_baud_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (TX_EN)                 state_nxt = ST_START;
      ST_START: if (tick_last)             state_nxt = ST_DATA;
      ST_DATA:  if (tick_last && last_bit) state_nxt = ST_STOP;
      ST_STOP:  if (tick_last)             state_nxt = ST_IDLE;
      default:                             state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    shreg_nxt    = shreg;
    tick_cnt_nxt = tick_cnt;
    bit_cnt_nxt  = bit_cnt;
    if (accept) begin
      shreg_nxt    = DATA;
      tick_cnt_nxt = '0;
      bit_cnt_nxt  = '0;
    end else if (state != ST_IDLE && tick) begin
      tick_cnt_nxt = tick_last ? '0 : tick_cnt + TICK_W'(1);
      if (tick_last && state == ST_DATA) begin
        shreg_nxt   = shreg >> 1;
        bit_cnt_nxt = bit_cnt + BIT_W'(1);
      end
    end
  end

  // Line level is decoded from next-state values so the registered TX
  // changes on the same edge as the state, keeping acceptance latency at 1.
  always_comb begin
    tx_d = 1'b1;
    case (state_nxt)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shreg_nxt[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      tx_q     <= 1'b1;
    end else begin
      shreg    <= shreg_nxt;
      tick_cnt <= tick_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      tx_q     <= tx_d;
    end
  end

  assign TX     = tx_q;
  assign STATUS = (state == ST_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx, run at a reduced clock/baud
// ratio (DIV = 3) so complete frames stay short.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int DIV   = 3;            // 1_300_000 / (25_000 * 16) = 3.25 -> 3
  localparam int BITP  = 16 * DIV;     // 48 clocks per bit
  localparam int FRAME = 160 * DIV;    // 480 clocks per frame

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       TX_EN = 1'b0;
  logic [7:0] DATA  = 8'h00;
  logic       TX, STATUS;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx #(
    .CLK_FREQ (1300000),
    .BAUD     (25000)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .DATA   (DATA),
    .TX_EN  (TX_EN),
    .TX     (TX),
    .STATUS (STATUS)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at the negedge right after acceptance (n = 0); returns at n = FRAME.
  task automatic frame(input logic [7:0] b, input string tag, input int mid_n,
                       input logic [7:0] mid_data, input logic mid_en, input logic pulse);
    int   bad = 0;
    int   k;
    logic exp;
    for (int n = 0; n <= FRAME; n++) begin
      if (n == FRAME) begin
        check({tag, "_status_end"}, STATUS, 1);
        check({tag, "_tx_end"}, TX, 1);
      end else begin
        k   = n / BITP;
        exp = (k == 0) ? 1'b0 : (k <= 8) ? b[k-1] : 1'b1;
        if (TX !== exp || STATUS !== 1'b0) bad++;
        if (n == 0) begin
          check({tag, "_tx_start"}, TX, 0);
          check({tag, "_status_busy"}, STATUS, 0);
        end
        if (n == mid_n) begin
          DATA  = mid_data;
          TX_EN = mid_en;
        end
        if (pulse && n == mid_n + 1) TX_EN = 1'b0;
        @(negedge clk);
      end
    end
    check({tag, "_bad_cycles"}, bad, 0);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int lows = 0;
    int busy = 0;
    repeat (cycles) begin
      if (TX !== 1'b1) lows++;
      if (STATUS !== 1'b1) busy++;
      @(negedge clk);
    end
    check({tag, "_tx_lows"}, lows, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic send(input logic [7:0] b);
    DATA  = b;
    TX_EN = 1'b1;
    @(negedge clk);
    TX_EN = 1'b0;
  endtask

  // Independent mid-bit sampler standing in for the receiver.
  task automatic rx_byte(input logic [7:0] b, input string tag);
    logic [7:0] got = '0;
    logic       start_b = 1'b1;
    logic       stop_b = 1'b0;
    logic       prev;
    int         rises = 0;
    int         j;
    send(b);
    prev = STATUS;
    for (int n = 0; n < FRAME + BITP; n++) begin
      if (n == BITP / 2) start_b = TX;
      if (n >= BITP / 2 + BITP && n < BITP / 2 + 9 * BITP && (n - BITP / 2) % BITP == 0) begin
        j = (n - BITP / 2) / BITP - 1;
        got[j] = TX;
      end
      if (n == BITP / 2 + 9 * BITP) stop_b = TX;
      if (STATUS && !prev) rises++;
      prev = STATUS;
      @(negedge clk);
    end
    check({tag, "_start"}, start_b, 0);
    check({tag, "_byte"}, got, b);
    check({tag, "_stop"}, stop_b, 1);
    check({tag, "_status_pulses"}, rises, 1);
  endtask

  initial begin
    check("div_default", calc_div(100000000, 9600), 651);
    check("div_bench", calc_div(1300000, 25000), 3);

    // Reset with TX_EN asserted: reset wins, no frame.
    rst   = 1'b1;
    DATA  = 8'h4B;
    TX_EN = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", TX, 1);
    check("rst_status", STATUS, 1);
    TX_EN = 1'b0;
    rst   = 1'b0;
    quiet("en_with_rst", 2 * BITP);

    // Acceptance in the very first cycle after reset release; 0x4B frame.
    rst = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    DATA  = 8'h4B;
    TX_EN = 1'b1;
    @(negedge clk);
    TX_EN = 1'b0;
    frame(8'h4B, "b4b", -1, 8'h00, 1'b0, 1'b0);

    // DATA change plus TX_EN pulse mid-frame are both ignored.
    send(8'hA5);
    frame(8'hA5, "ba5", 5 * BITP + 7, 8'hFF, 1'b1, 1'b1);
    quiet("ba5_no_second", 2 * BITP);

    // TX_EN held: back-to-back frames with a fresh DATA sample each.
    DATA  = 8'h00;
    TX_EN = 1'b1;
    @(negedge clk);
    frame(8'h00, "held0", BITP, 8'hFF, 1'b1, 1'b0);
    @(negedge clk);
    frame(8'hFF, "held1", BITP, 8'hFF, 1'b0, 1'b0);
    quiet("held_end", 2 * BITP);

    // Reset during data bit 3 of 0x55 aborts the frame.
    send(8'h55);
    repeat (4 * BITP + 10) @(negedge clk);
    check("abort_bit3", TX, 0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_tx", TX, 1);
    check("abort_status", STATUS, 1);
    rst = 1'b0;
    quiet("abort_after", FRAME);

    rx_byte(8'h00, "rx00");
    rx_byte(8'h55, "rx55");
    rx_byte(8'hAA, "rxaa");
    rx_byte(8'hFF, "rxff");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
